uart_cmd_framer: RTL
====================

// Module: uart_cmd_framer
// PURPOSE
//  Sits between the copter-side UART transceiver and cmd_cfg.
//  Assembles 3 received bytes (cmd, data_hi, data_lo) into one command frame and
//  presents it atomically with cmd_rdy.
//  Serialises single-byte responses (battery level, positive ack 8'hA5) back out
//  through the UART transmitter.
//  Discards partial frames after an inter-byte timeout so a lost byte cannot
//  misalign later frames.
// PARAMETERS
//  TO_W     16      width of inter-byte timeout counter
//  TIMEOUT  16'hFFFF  clk cycles allowed between bytes of one frame before discard
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  rx_rdy       in   1   UART receiver has a byte in rx_data (level, held until cleared)
//  rx_data      in   8   received byte
//  clr_rx_rdy   out  1   one-cycle pulse: byte consumed, receiver drops rx_rdy
//  cmd_rdy      out  1   complete frame available on cmd/data
//  cmd          out  8   opcode of last complete frame
//  data         out  16  {data_hi,data_lo} of last complete frame
//  clr_cmd_rdy  in   1   consumer acknowledges frame
//  overrun      out  1   one-cycle pulse: frame completed while cmd_rdy still high
//  frm_err      out  1   one-cycle pulse: partial frame discarded on timeout
//  resp         in   8   response byte to send
//  send_resp    in   1   request to transmit resp
//  tx_data      out  8   byte to UART transmitter
//  trmt         out  1   one-cycle start pulse to transmitter
//  tx_done      in   1   transmitter finished current byte (pulse)
//  resp_sent    out  1   one-cycle pulse after tx_done for our byte
// BEHAVIOUR
//  Reset: every output 0, both FSMs idle, shadow regs and timeout counter 0.
//  RX FSM states: WAIT_CMD -> WAIT_HI -> WAIT_LO -> WAIT_CMD.
//  - Byte accepted in a cycle where rx_rdy=1 and no clr_rx_rdy is pending.
//    Next cycle: clr_rx_rdy=1 for exactly one cycle.
//    rx_rdy is ignored in that cycle (receiver still holds it), so one byte is
//    never counted twice.
//  - WAIT_CMD: rx_data -> cmd_sh, go WAIT_HI, timeout cnt cleared.
//  - WAIT_HI: rx_data -> hi_sh, go WAIT_LO, cnt cleared.
//  - WAIT_LO: on accept, next cycle cmd<=cmd_sh, data<={hi_sh,rx_data}, cmd_rdy<=1.
//    FSM goes to WAIT_CMD.
//    Latency: last byte accepted at edge N -> cmd_rdy and clr_rx_rdy high after edge N+1.
//  - cmd/data change only at frame completion and hold otherwise; never show a
//    partial frame.
//  - cmd_rdy clears on clr_cmd_rdy.
//    Completion in same cycle as clr_cmd_rdy: set wins, cmd_rdy stays 1.
//    Completion with cmd_rdy already 1: outputs overwritten, overrun pulses 1 cycle.
//  - Timeout: in WAIT_HI/WAIT_LO the counter increments each cycle with no accept.
//    When it reaches TIMEOUT: FSM goes to WAIT_CMD, frm_err pulses, shadows left
//    stale, cmd/data/cmd_rdy untouched.
//    Counter held at 0 in WAIT_CMD; no timeout while idle.
//    Saturation at TIMEOUT: no wrap.
//  TX FSM states: TX_IDLE, TX_BUSY.
//  - TX_IDLE and send_resp=1: next cycle tx_data<=resp, trmt=1 for one cycle,
//    go TX_BUSY.
//  - TX_BUSY: tx_data held; send_resp ignored (request dropped, no queue).
//    tx_done -> resp_sent pulse next cycle, back to TX_IDLE.
//    A new send_resp in that same cycle is accepted.
//  - tx_done in TX_IDLE is ignored.
//  RX and TX paths are independent; simultaneous activity is legal.
//  rst asserted mid-frame or mid-transmit: immediate return to reset state,
//  partial frame lost, trmt/clr_rx_rdy low.
// TESTING
//  1 Bytes 8'h02,8'h00,8'h3A with rx_rdy handshake -> cmd=02, data=003A, cmd_rdy=1
//    one cycle after 3rd accept; exactly 3 clr_rx_rdy pulses.
//  2 rx_rdy held high for 5 cycles on one byte -> only 1 byte accepted, FSM in WAIT_HI.
//  3 Send 8'h04, 8'h80, then idle TIMEOUT+1 cycles -> frm_err pulse, cmd_rdy=0.
//    Then 04,80,0A -> data=800A.
//  4 Frame A complete, no clr; frame B (05,00,FD) completes -> overrun pulse,
//    cmd=05, data=00FD. clr_cmd_rdy asserted same cycle as completion -> cmd_rdy stays 1.
//  5 send_resp with resp=8'hA5 -> trmt pulse, tx_data=A5.
//    send_resp with 8'hC0 while busy is ignored.
//    tx_done -> resp_sent pulse, back to TX_IDLE.
//  6 rst pulsed after 2 of 3 bytes -> all outputs 0.
//    Next 3-byte frame decodes correctly, no misalignment.

Source files
------------

// File: rtl/uart_cmd_framer.sv
// Bridges a byte-wide UART to a 3-byte command interface (cmd, data_hi, data_lo) and
// serialises single-byte responses back to the UART transmitter.
module uart_cmd_framer #(
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  output logic        frm_err,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic [1:0]  rx_state_dbg,
  output logic        tx_state_dbg
);

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  rx_state_t       rx_state;
  tx_state_t       tx_state;
  logic [7:0]      cmd_sh;
  logic [7:0]      hi_sh;
  logic [TO_W-1:0] to_cnt;
  logic            clr_pend;
  logic            accept;

  // Handshake: a byte is taken when rx_rdy is high and no clear is pending; the clear
  // stays pending until the receiver has been seen to drop rx_rdy, so a held byte is
  // never taken twice.
  assign accept       = rx_rdy & ~clr_pend;
  assign rx_state_dbg = rx_state;
  assign tx_state_dbg = tx_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= WAIT_CMD;
      cmd_sh     <= 8'h00;
      hi_sh      <= 8'h00;
      to_cnt     <= '0;
      clr_pend   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      cmd_rdy    <= 1'b0;
      cmd        <= 8'h00;
      data       <= 16'h0000;
      overrun    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      clr_rx_rdy <= accept;
      overrun    <= 1'b0;
      frm_err    <= 1'b0;
      if (accept) begin
        clr_pend <= 1'b1;
      end else if (!rx_rdy) begin
        clr_pend <= 1'b0;
      end
      // A completion later in this block overrides the clear, so set wins.
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      case (rx_state)
        WAIT_CMD: begin
          to_cnt <= '0;
          if (accept) begin
            cmd_sh   <= rx_data;
            rx_state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (accept) begin
            hi_sh    <= rx_data;
            to_cnt   <= '0;
            rx_state <= WAIT_LO;
          end else if (to_cnt == TIMEOUT) begin
            to_cnt   <= '0;
            frm_err  <= 1'b1;
            rx_state <= WAIT_CMD;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WAIT_LO: begin
          if (accept) begin
            cmd      <= cmd_sh;
            data     <= {hi_sh, rx_data};
            cmd_rdy  <= 1'b1;
            overrun  <= cmd_rdy;
            to_cnt   <= '0;
            rx_state <= WAIT_CMD;
          end else if (to_cnt == TIMEOUT) begin
            to_cnt   <= '0;
            frm_err  <= 1'b1;
            rx_state <= WAIT_CMD;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: begin
          to_cnt   <= '0;
          rx_state <= WAIT_CMD;
        end
      endcase
    end
  end

  // Single-entry transmit path: requests arriving while busy are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_data   <= 8'h00;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data  <= resp;
            trmt     <= 1'b1;
            tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done) begin
            resp_sent <= 1'b1;
            tx_state  <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
